mem_access: RTL and testbench

//  Memory stage of the 5-stage RISC-V pipe; sits between ex_mem and mem_wb.

---
 rtl/mem_access_pkg.sv | 45 ++++
 rtl/mem_access_if.sv | 27 ++
 rtl/mem_lsu_align.sv | 70 +++++++
 rtl/mem_access.sv | 169 ++++++++++++++++
 tb/tb_mem_access.sv | 361 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared constants, FSM encodings and size helpers for the memory stage
// Purpose: funct3 load codes, FSM state encodings, access-size decode and the
//          alignment rule shared by the top and the lane aligner.
// Ports:   none (package).
package mem_access_pkg;

  localparam int XLEN = 32;

  // Load funct3 codes (stores reuse the low two bits as the size field).
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // FSM encodings kept as plain constants for compatibility with older code.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } acc_size_e;

  // funct3[1:0] is the size for both loads and stores; the unused code 2'b11
  // is treated as a word so it can never produce a partial byte enable.
  function automatic acc_size_e size_of(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   size_of = SZ_BYTE;
      2'b01:   size_of = SZ_HALF;
      default: size_of = SZ_WORD;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
    case (size_of(funct3))
      SZ_HALF: is_misaligned = off[0];
      SZ_WORD: is_misaligned = |off;
      default: is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// rtl/mem_access_if.sv - data-bus interface between the memory stage and the data memory
// Purpose: bundles the req/gnt/rvalid data bus.
// Ports:   master (memory stage): drives req/we/addr/be/wdata, receives gnt/rvalid/rdata.
//          slave  (memory/bench): the opposite directions.
interface mem_access_if;
  import mem_access_pkg::*;

  logic            dbus_req_o;
  logic            dbus_we_o;
  logic [XLEN-1:0] dbus_addr_o;
  logic [3:0]      dbus_be_o;
  logic [XLEN-1:0] dbus_wdata_o;
  logic            dbus_gnt_i;
  logic            dbus_rvalid_i;
  logic [XLEN-1:0] dbus_rdata_i;

  modport master (
    output dbus_req_o, dbus_we_o, dbus_addr_o, dbus_be_o, dbus_wdata_o,
    input  dbus_gnt_i, dbus_rvalid_i, dbus_rdata_i
  );

  modport slave (
    input  dbus_req_o, dbus_we_o, dbus_addr_o, dbus_be_o, dbus_wdata_o,
    output dbus_gnt_i, dbus_rvalid_i, dbus_rdata_i
  );

endinterface

// File: rtl/mem_lsu_align.sv
// rtl/mem_lsu_align.sv - combinational byte-lane aligner for loads and stores
// Purpose: for the incoming access, generates byte enables, lane-replicated
//          store data and the misalignment flag; for the returning load word,
//          selects the addressed lane and sign/zero-extends it.
// Ports:   req_funct3_i/req_off_i/req_wdata_i -> req_be_o/req_wdata_o/req_misalign_o
//          ld_funct3_i/ld_off_i/ld_rdata_i    -> ld_data_o
module mem_lsu_align
  import mem_access_pkg::*;
(
  input  logic [2:0]      req_funct3_i,
  input  logic [1:0]      req_off_i,
  input  logic [XLEN-1:0] req_wdata_i,
  output logic [3:0]      req_be_o,
  output logic [XLEN-1:0] req_wdata_o,
  output logic            req_misalign_o,
  input  logic [2:0]      ld_funct3_i,
  input  logic [1:0]      ld_off_i,
  input  logic [XLEN-1:0] ld_rdata_i,
  output logic [XLEN-1:0] ld_data_o
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign req_misalign_o = is_misaligned(req_funct3_i, req_off_i);

  // Store data is replicated across all lanes so the memory only has to
  // honour the byte enables, never shift.
  always_comb begin
    req_be_o    = 4'hF;
    req_wdata_o = req_wdata_i;
    case (size_of(req_funct3_i))
      SZ_BYTE: begin
        req_be_o    = 4'b0001 << req_off_i;
        req_wdata_o = {4{req_wdata_i[7:0]}};
      end
      SZ_HALF: begin
        req_be_o    = 4'b0011 << req_off_i;
        req_wdata_o = {2{req_wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    lane_b = ld_rdata_i[7:0];
    case (ld_off_i)
      2'd1:    lane_b = ld_rdata_i[15:8];
      2'd2:    lane_b = ld_rdata_i[23:16];
      2'd3:    lane_b = ld_rdata_i[31:24];
      default: ;
    endcase
  end

  // Halfwords are only ever aligned here, so off[1] alone picks the lane.
  assign lane_h = ld_off_i[1] ? ld_rdata_i[31:16] : ld_rdata_i[15:0];

  always_comb begin
    ld_data_o = ld_rdata_i;
    case (ld_funct3_i)
      F3_LB:   ld_data_o = {{24{lane_b[7]}}, lane_b};
      F3_LBU:  ld_data_o = {24'b0, lane_b};
      F3_LH:   ld_data_o = {{16{lane_h[15]}}, lane_h};
      F3_LHU:  ld_data_o = {16'b0, lane_h};
      F3_LW:   ld_data_o = ld_rdata_i;
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// rtl/mem_access.sv - pipeline memory stage: one data-bus transaction per load/store
// Purpose: sits between ex_mem and mem_wb. Non-memory results pass through with
//          one registered cycle. Aligned loads/stores run IDLE->REQ(->WAIT)->IDLE
//          on the req/gnt/rvalid bus while hold_o stalls the upstream pipe;
//          misaligned accesses are dropped with a misalign_o pulse; accesses
//          that stay open TIMEOUT_CYCLES cycles are abandoned with a bus_err_o pulse.
// Ports:   clk_100MHz, arst_n (async active-low)
//          mem_r_*/mem_w_*/inst_i/reg_w_*_i : from ex_mem
//          dbus                             : data bus (master side)
//          hold_o                           : stall to pc/if_id/id_ex/ex_mem
//          reg_w_*_o                        : registered result to mem_wb
//          misalign_o, bus_err_o            : single-cycle error pulses
module mem_access
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic            clk_100MHz,
  input  logic            arst_n,
  input  logic            mem_r_ena_i,
  input  logic [XLEN-1:0] mem_r_addr_i,
  input  logic            mem_w_ena_i,
  input  logic [XLEN-1:0] mem_w_addr_i,
  input  logic [XLEN-1:0] mem_w_data_i,
  input  logic [XLEN-1:0] inst_i,
  input  logic [4:0]      reg_w_addr_i,
  input  logic            reg_w_ena_i,
  input  logic [XLEN-1:0] reg_w_data_i,
  mem_access_if.master    dbus,
  output logic            hold_o,
  output logic [4:0]      reg_w_addr_o,
  output logic            reg_w_ena_o,
  output logic [XLEN-1:0] reg_w_data_o,
  output logic            misalign_o,
  output logic            bus_err_o
);

  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;

  // Transaction latched at IDLE exit; ex_mem is stalled but the bus view must
  // not depend on it.
  logic             we_q;
  logic [29:0]      addr_q;
  logic [1:0]       off_q;
  logic [3:0]       be_q;
  logic [XLEN-1:0]  wdata_q;
  logic [2:0]       funct3_q;
  logic [4:0]       rd_q;
  logic             rd_ena_q;

  logic             access, is_load;
  logic [XLEN-1:0]  in_addr;
  logic [3:0]       be_new;
  logic [XLEN-1:0]  wdata_new;
  logic             mis_new;
  logic [XLEN-1:0]  ld_data;

  logic             idle, busy, start, mis_drop;
  logic             st_done, ld_done, complete, timeout;
  logic             unused_inst;

  assign unused_inst = ^{inst_i[31:15], inst_i[11:0]};

  // Load wins when both enables are set; the store is dropped.
  assign is_load = mem_r_ena_i;
  assign access  = mem_r_ena_i | mem_w_ena_i;
  assign in_addr = is_load ? mem_r_addr_i : mem_w_addr_i;

  mem_lsu_align u_align (
    .req_funct3_i   (inst_i[14:12]),
    .req_off_i      (in_addr[1:0]),
    .req_wdata_i    (mem_w_data_i),
    .req_be_o       (be_new),
    .req_wdata_o    (wdata_new),
    .req_misalign_o (mis_new),
    .ld_funct3_i    (funct3_q),
    .ld_off_i       (off_q),
    .ld_rdata_i     (dbus.dbus_rdata_i),
    .ld_data_o      (ld_data)
  );

  assign idle     = (state_q == ST_IDLE);
  assign busy     = !idle;
  assign start    = idle && access && !mis_new;
  assign mis_drop = idle && access && mis_new;
  assign st_done  = (state_q == ST_REQ) && dbus.dbus_gnt_i && we_q;
  assign ld_done  = (state_q == ST_WAIT) && dbus.dbus_rvalid_i;
  assign complete = st_done || ld_done;
  // A load granted in its last allowed cycle still counts as timed out: the
  // whole REQ+WAIT window is bounded, not each phase.
  assign timeout  = busy && !complete && (cnt_q == CNT_LAST);

  // hold drops in the completion (or timeout) cycle so ex_mem advances on that
  // same edge and the access is not reissued.
  assign hold_o = start || (busy && !complete && !timeout);

  assign dbus.dbus_req_o   = (state_q == ST_REQ);
  assign dbus.dbus_we_o    = we_q;
  assign dbus.dbus_addr_o  = {addr_q, 2'b00};
  assign dbus.dbus_be_o    = be_q;
  assign dbus.dbus_wdata_o = wdata_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_REQ;
      ST_REQ:  if (dbus.dbus_gnt_i) state_d = we_q ? ST_IDLE : ST_WAIT;
      ST_WAIT: if (dbus.dbus_rvalid_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (timeout) state_d = ST_IDLE;
  end

  always_ff @(posedge clk_100MHz or negedge arst_n) begin
    if (!arst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      off_q        <= '0;
      be_q         <= '0;
      wdata_q      <= '0;
      funct3_q     <= '0;
      rd_q         <= '0;
      rd_ena_q     <= 1'b0;
      reg_w_addr_o <= '0;
      reg_w_ena_o  <= 1'b0;
      reg_w_data_o <= '0;
      misalign_o   <= 1'b0;
      bus_err_o    <= 1'b0;
    end else begin
      state_q    <= state_d;
      misalign_o <= mis_drop;
      bus_err_o  <= timeout;

      if (state_d == ST_IDLE || idle) cnt_q <= '0;
      else                            cnt_q <= cnt_q + 1'b1;

      if (start) begin
        we_q     <= !is_load;
        addr_q   <= in_addr[31:2];
        off_q    <= in_addr[1:0];
        be_q     <= be_new;
        wdata_q  <= wdata_new;
        funct3_q <= inst_i[14:12];
        rd_q     <= reg_w_addr_i;
        rd_ena_q <= reg_w_ena_i;
      end

      if (ld_done) begin
        reg_w_addr_o <= rd_q;
        reg_w_ena_o  <= rd_ena_q;
        reg_w_data_o <= ld_data;
      end else if (busy) begin
        // Bubble to mem_wb while held, on store completion and on timeout.
        reg_w_ena_o <= 1'b0;
      end else begin
        reg_w_addr_o <= reg_w_addr_i;
        reg_w_data_o <= reg_w_data_i;
        reg_w_ena_o  <= reg_w_ena_i && !access;
      end
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - scoreboard testbench for the mem_access memory stage
module tb_mem_access;
  import mem_access_pkg::*;

  localparam int EV_WB = 0, EV_ST = 1, EV_LD = 2, EV_MIS = 3, EV_ERR = 4;

  typedef struct {
    int          kind;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
  } ev_t;

  // kind: 0 non-memory, 1 load, 2 store, 3 load+store enables together
  typedef struct {
    int          kind;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic        rd_ena;
    logic [31:0] alu;
    int          gd;
    int          rdl;
    logic [31:0] rdata;
  } instr_t;

  typedef struct {
    bit          is_load;
    int          gd;
    int          rdl;
    logic [31:0] rdata;
  } bus_t;

  logic        clk_100MHz = 1'b0;
  logic        arst_n;
  logic        mem_r_ena_i, mem_w_ena_i, reg_w_ena_i;
  logic [31:0] mem_r_addr_i, mem_w_addr_i, mem_w_data_i, inst_i, reg_w_data_i;
  logic [4:0]  reg_w_addr_i;
  logic        hold_o, reg_w_ena_o, misalign_o, bus_err_o;
  logic [4:0]  reg_w_addr_o;
  logic [31:0] reg_w_data_o;

  mem_access_if dbus ();

  mem_access #(.TIMEOUT_CYCLES(16)) dut (
    .clk_100MHz   (clk_100MHz),
    .arst_n       (arst_n),
    .mem_r_ena_i  (mem_r_ena_i),
    .mem_r_addr_i (mem_r_addr_i),
    .mem_w_ena_i  (mem_w_ena_i),
    .mem_w_addr_i (mem_w_addr_i),
    .mem_w_data_i (mem_w_data_i),
    .inst_i       (inst_i),
    .reg_w_addr_i (reg_w_addr_i),
    .reg_w_ena_i  (reg_w_ena_i),
    .reg_w_data_i (reg_w_data_i),
    .dbus         (dbus),
    .hold_o       (hold_o),
    .reg_w_addr_o (reg_w_addr_o),
    .reg_w_ena_o  (reg_w_ena_o),
    .reg_w_data_o (reg_w_data_o),
    .misalign_o   (misalign_o),
    .bus_err_o    (bus_err_o)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  int   checks = 0;
  int   errors = 0;
  ev_t  exp_q[$];
  bus_t bus_q[$];

  function automatic ev_t mkev(int kind, logic [31:0] a, logic [31:0] b, logic [31:0] c);
    ev_t e;
    e.kind = kind; e.a = a; e.b = b; e.c = c;
    return e;
  endfunction

  function automatic instr_t mk(int kind, logic [2:0] f3, logic [31:0] addr, logic [31:0] wdata,
                                int gd, int rdl, logic [31:0] rdata);
    instr_t t;
    t.kind = kind; t.f3 = f3; t.addr = addr; t.wdata = wdata;
    t.gd = gd; t.rdl = rdl; t.rdata = rdata;
    t.waddr = $urandom; t.rd = 5'($urandom); t.rd_ena = 1'b1; t.alu = $urandom;
    return t;
  endfunction

  // Reference rules: size from funct3[1:0], natural alignment required.
  function automatic bit model_misaligned(logic [2:0] f3, logic [1:0] off);
    if (f3[1:0] == 2'b00) return 0;
    if (f3[1:0] == 2'b01) return (off % 2) != 0;
    return off != 0;
  endfunction

  function automatic logic [31:0] model_load(logic [2:0] f3, logic [1:0] off, logic [31:0] w);
    int unsigned v;
    v = w >> (8 * off);
    case (f3)
      3'b000: begin v = v & 32'hFF;   if (v >= 128)   v = v | 32'hFFFFFF00; end
      3'b001: begin v = v & 32'hFFFF; if (v >= 32768) v = v | 32'hFFFF0000; end
      3'b100: v = v & 32'hFF;
      3'b101: v = v & 32'hFFFF;
      default: v = w;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] model_be(logic [2:0] f3, logic [1:0] off);
    if (f3[1:0] == 2'b00) return 32'(1 << off);
    if (f3[1:0] == 2'b01) return 32'(3 << off);
    return 32'hF;
  endfunction

  function automatic logic [31:0] model_wdata(logic [2:0] f3, logic [31:0] d);
    if (f3[1:0] == 2'b00) return d[7:0] * 32'h01010101;
    if (f3[1:0] == 2'b01) return d[15:0] * 32'h00010001;
    return d;
  endfunction

  task automatic got(input ev_t e, input string nm);
    ev_t x;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s unexpected event a=%h b=%h c=%h", nm, e.a, e.b, e.c);
    end else begin
      x = exp_q.pop_front();
      if (x.kind != e.kind || x.a != e.a || x.b != e.b || x.c != e.c) begin
        errors++;
        $display("FAIL %s got kind=%0d a=%h b=%h c=%h expected kind=%0d a=%h b=%h c=%h",
                 nm, e.kind, e.a, e.b, e.c, x.kind, x.a, x.b, x.c);
      end
    end
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic drive_idle();
    mem_r_ena_i = 0; mem_w_ena_i = 0; reg_w_ena_i = 0;
    mem_r_addr_i = 0; mem_w_addr_i = 0; mem_w_data_i = 0;
    inst_i = 0; reg_w_addr_i = 0; reg_w_data_i = 0;
  endtask

  // Called at posedge+1; returns at posedge+1 after ex_mem consumed the instruction.
  task automatic issue(input instr_t t);
    bit   mem, ld, tmo;
    int   exp_hold, held;
    bit   h;
    bus_t b;
    logic [31:0] inst;
    mem = (t.kind != 0);
    ld  = (t.kind == 1 || t.kind == 3);
    exp_hold = 0;
    if (!mem) begin
      if (t.rd_ena) exp_q.push_back(mkev(EV_WB, {27'b0, t.rd}, t.alu, 0));
    end else if (model_misaligned(t.f3, t.addr[1:0])) begin
      exp_q.push_back(mkev(EV_MIS, 0, 0, 0));
    end else begin
      tmo = ((ld ? t.gd + t.rdl + 2 : t.gd + 1) > 16);
      b.is_load = ld; b.gd = t.gd; b.rdl = t.rdl; b.rdata = t.rdata;
      bus_q.push_back(b);
      if (tmo) begin
        exp_q.push_back(mkev(EV_ERR, 0, 0, 0));
        exp_hold = 16;
      end else if (ld) begin
        exp_q.push_back(mkev(EV_LD, t.addr & 32'hFFFFFFFC, 0, 0));
        if (t.rd_ena)
          exp_q.push_back(mkev(EV_WB, {27'b0, t.rd}, model_load(t.f3, t.addr[1:0], t.rdata), 0));
        exp_hold = 2 + t.gd + t.rdl;
      end else begin
        exp_q.push_back(mkev(EV_ST, t.addr & 32'hFFFFFFFC, model_be(t.f3, t.addr[1:0]),
                             model_wdata(t.f3, t.wdata)));
        exp_hold = 1 + t.gd;
      end
    end
    inst = $urandom;
    inst[14:12] = t.f3;
    mem_r_ena_i  = ld;
    mem_w_ena_i  = (t.kind == 2 || t.kind == 3);
    mem_r_addr_i = ld ? t.addr : $urandom;
    mem_w_addr_i = (t.kind == 2) ? t.addr : t.waddr;
    mem_w_data_i = t.wdata;
    inst_i       = inst;
    reg_w_addr_i = t.rd;
    reg_w_ena_i  = t.rd_ena;
    reg_w_data_i = t.alu;
    held = 0;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk_100MHz);
      h = hold_o;
      @(posedge clk_100MHz);
      #1;
      if (!h) break;
      held++;
    end
    check("hold_cycles", 64'(held), 64'(exp_hold));
  endtask

  // Bus slave: grants after gd REQ cycles, returns data after rdl WAIT cycles;
  // an abandoned request gets one stray rvalid while the stage is idle.
  initial begin
    int   phase;
    int   cd;
    bus_t cur;
    phase = 0; cd = 0;
    dbus.dbus_gnt_i = 0; dbus.dbus_rvalid_i = 0; dbus.dbus_rdata_i = 0;
    forever begin
      @(posedge clk_100MHz);
      #1;
      dbus.dbus_gnt_i = 0;
      dbus.dbus_rvalid_i = 0;
      if (!arst_n) begin
        phase = 0;
      end else begin
        if (phase == 0 && dbus.dbus_req_o) begin
          if (bus_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_req addr=%h required no request", dbus.dbus_addr_o);
          end else begin
            cur = bus_q.pop_front();
            cd = cur.gd;
            phase = 1;
          end
        end
        if (phase == 1) begin
          if (!dbus.dbus_req_o) begin
            phase = 0;
            dbus.dbus_rvalid_i = 1;
            dbus.dbus_rdata_i = $urandom;
          end else if (cd == 0) begin
            dbus.dbus_gnt_i = 1;
            phase = cur.is_load ? 2 : 0;
            cd = cur.rdl;
          end else begin
            cd--;
          end
        end else if (phase == 2) begin
          if (cd == 0) begin
            dbus.dbus_rvalid_i = 1;
            dbus.dbus_rdata_i = cur.rdata;
            phase = 0;
          end else begin
            cd--;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk_100MHz);
      if (arst_n) begin
        if (reg_w_ena_o) got(mkev(EV_WB, {27'b0, reg_w_addr_o}, reg_w_data_o, 0), "wb");
        if (misalign_o)  got(mkev(EV_MIS, 0, 0, 0), "misalign");
        if (bus_err_o)   got(mkev(EV_ERR, 0, 0, 0), "bus_err");
        if (dbus.dbus_req_o && dbus.dbus_gnt_i) begin
          if (dbus.dbus_we_o)
            got(mkev(EV_ST, dbus.dbus_addr_o, {28'b0, dbus.dbus_be_o}, dbus.dbus_wdata_o), "store");
          else
            got(mkev(EV_LD, dbus.dbus_addr_o, 0, 0), "load_req");
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

  function automatic logic [63:0] all_outs();
    return {19'b0, hold_o, reg_w_ena_o, misalign_o, bus_err_o, reg_w_addr_o,
            dbus.dbus_req_o, dbus.dbus_we_o, dbus.dbus_be_o,
            (dbus.dbus_addr_o | dbus.dbus_wdata_o | reg_w_data_o) != 32'h0};
  endfunction

  initial begin
    instr_t t;
    bus_t   b;
    int     k, gd;
    logic [2:0]  f3;
    logic [31:0] a;

    drive_idle();
    arst_n = 1;
    #1 arst_n = 0;
    #1 check("reset_outputs", all_outs(), 64'h0);
    repeat (3) @(posedge clk_100MHz);
    @(negedge clk_100MHz) arst_n = 1;
    @(posedge clk_100MHz);
    #1;

    // LW best case: hold T0..T1, result at T3.
    issue(mk(1, F3_LW, 32'h100, 0, 0, 0, 32'hDEADBEEF));
    check("lw_t3_data", {31'b0, reg_w_ena_o, reg_w_data_o}, {32'h1, 32'hDEADBEEF});
    issue(mk(1, F3_LB, 32'h103, 0, 0, 1, 32'h80FFFFFF));
    issue(mk(1, F3_LBU, 32'h103, 0, 1, 0, 32'h80FFFFFF));
    issue(mk(2, 3'b001, 32'h102, 32'h1234, 0, 0, 0));
    issue(mk(1, F3_LW, 32'h101, 0, 0, 0, 0));
    issue(mk(0, 3'b000, 0, 0, 0, 0, 0));
    issue(mk(1, F3_LW, 32'h100, 0, 99, 0, 32'h11111111));
    issue(mk(3, F3_LH, 32'h206, 32'h5555, 2, 2, 32'hABCD7FFF));

    // Reset while waiting for rvalid.
    b.is_load = 1; b.gd = 0; b.rdl = 1000; b.rdata = 0;
    bus_q.push_back(b);
    exp_q.push_back(mkev(EV_LD, 32'h200, 0, 0));
    mem_r_ena_i = 1; mem_r_addr_i = 32'h200; inst_i = 32'h00002003;
    reg_w_addr_i = 5'd7; reg_w_ena_i = 1;
    repeat (3) begin @(posedge clk_100MHz); #1; end
    check("wait_hold", {63'b0, hold_o}, 64'h1);
    drive_idle();
    #2 arst_n = 0;
    #1 check("midwait_reset_outputs", all_outs(), 64'h0);
    @(posedge clk_100MHz);
    #1;
    @(negedge clk_100MHz) arst_n = 1;
    @(posedge clk_100MHz);
    #1;
    issue(mk(1, F3_LW, 32'h300, 0, 1, 1, 32'hCAFEF00D));

    for (int n = 0; n < 300; n++) begin
      k = $urandom_range(0, 3);
      if (k == 2) begin
        f3 = 3'($urandom_range(0, 2));
      end else begin
        case ($urandom_range(0, 4))
          0: f3 = F3_LB;
          1: f3 = F3_LH;
          2: f3 = F3_LW;
          3: f3 = F3_LBU;
          default: f3 = F3_LHU;
        endcase
      end
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      gd = ($urandom_range(0, 11) == 0) ? 99 : int'($urandom_range(0, 3));
      t = mk(k, f3, a, $urandom, gd, int'($urandom_range(0, 3)), $urandom);
      t.rd_ena = ($urandom_range(0, 5) != 0);
      issue(t);
    end

    drive_idle();
    repeat (5) @(posedge clk_100MHz);
    #1;
    check("queues_drained", 64'(exp_q.size() + bus_q.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
